// File: rtl/apb_bridge_pkg.sv
// rtl/apb_bridge_pkg.sv - shared state, request/response layouts and widths for the APB side of the bridge
package apb_bridge_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int STRB_W     = APB_DATA_W / 8;
  localparam int REQ_W      = 1 + APB_ADDR_W + APB_DATA_W + STRB_W;
  localparam int RESP_W     = APB_DATA_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
    logic [STRB_W-1:0]     strb;
  } req_t;

  typedef struct packed {
    logic                  is_write;
    logic                  slverr;
    logic [APB_DATA_W-1:0] rdata;
  } resp_t;

endpackage

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - APB4 master draining the request FIFO and filling the response FIFO, one transfer at a time
// APB_TIMEOUT_EN adds an ACCESS-phase timeout of TIMEOUT_CYCLES cycles that completes the transfer with slverr.
module apb_master_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_W+DATA_W+DATA_W/8:0] req_data,
  input  logic                          req_empty,
  output logic                          req_pop,
  output logic [DATA_W+1:0]             resp_data,
  input  logic                          resp_full,
  output logic                          resp_push,
  output logic [ADDR_W-1:0]             paddr,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [DATA_W-1:0]             pwdata,
  output logic [DATA_W/8-1:0]           pstrb,
  input  logic [DATA_W-1:0]             prdata,
  input  logic                          pready,
  input  logic                          pslverr,
  output logic                          busy
);
  import apb_bridge_pkg::*;

  localparam int SW = DATA_W / 8;

  if ((DATA_W % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("apb_master_ctrl: DATA_W must be a multiple of 8 and TIMEOUT_CYCLES at least 1");
  end

  state_t            state_q, state_d;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SW-1:0]     strb_q;
  logic [DATA_W+1:0] resp_q;

  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [SW-1:0]     req_strb;
  logic              access_timeout;

  assign req_wr    = req_data[ADDR_W+DATA_W+SW];
  assign req_addr  = req_data[DATA_W+SW +: ADDR_W];
  assign req_wdata = req_data[SW +: DATA_W];
  assign req_strb  = req_data[SW-1:0];

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] acc_cnt_q;

  // Counts completed ACCESS cycles without pready; cleared during SETUP so it starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      acc_cnt_q <= '0;
    end else if (state_q == ACCESS && !pready) begin
      acc_cnt_q <= acc_cnt_q + 1'b1;
    end
  end

  assign access_timeout = (state_q == ACCESS) && !pready &&
                          (acc_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign access_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!req_empty) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || access_timeout) state_d = RESP;
      RESP:    if (!resp_full) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reads never carry write data or strobes onto the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (req_pop) begin
      wr_q    <= req_wr;
      addr_q  <= req_addr;
      wdata_q <= req_wr ? req_wdata : '0;
      strb_q  <= req_wr ? req_strb : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q <= '0;
    end else if (state_q == ACCESS) begin
      if (pready) begin
        resp_q <= {wr_q, pslverr, (wr_q ? {DATA_W{1'b0}} : prdata)};
      end else if (access_timeout) begin
        resp_q <= {wr_q, 1'b1, {DATA_W{1'b0}}};
      end
    end
  end

  assign req_pop   = (state_q == IDLE) && !req_empty;
  assign resp_push = (state_q == RESP) && !resp_full;
  assign resp_data = resp_q;
  assign psel      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable   = (state_q == ACCESS);
  assign paddr     = addr_q;
  assign pwrite    = wr_q;
  assign pwdata    = wdata_q;
  assign pstrb     = strb_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb/tb_apb_master_ctrl.sv - scoreboard bench for apb_master_ctrl with a FIFO model and a wait-state APB slave
module tb_apb_master_ctrl;
  import apb_bridge_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [REQ_W-1:0]  req_data = '0;
  logic              req_empty = 1'b1;
  logic              req_pop;
  logic [RESP_W-1:0] resp_data;
  logic              resp_full = 1'b0;
  logic              resp_push;
  logic [31:0]       paddr;
  logic              psel, penable, pwrite;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [31:0]       prdata = '0;
  logic              pready = 1'b0;
  logic              pslverr = 1'b0;
  logic              busy;

  always #5 clk = ~clk;

  apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_data(req_data), .req_empty(req_empty), .req_pop(req_pop),
    .resp_data(resp_data), .resp_full(resp_full), .resp_push(resp_push),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .busy(busy)
  );

  typedef struct {
    int          waits;
    logic [31:0] rdata;
    logic        slverr;
  } slv_cfg_t;

  logic [REQ_W-1:0]  fifo_q[$];
  req_t              exp_apb_q[$];
  resp_t             exp_resp_q[$];
  slv_cfg_t          slv_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, pop_cnt = 0, push_cnt = 0, bad_pop = 0, bad_push = 0;
  int t_pop = 0, t_setup = 0, t_acc = 0, t_push = 0, acc_len = 0;
  bit pop_pending = 1'b0;
  req_t cur_req = '0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh_fifo();
    req_empty = (fifo_q.size() == 0);
    req_data  = req_empty ? '0 : fifo_q[0];
  endtask

  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int waits, input logic [31:0] rdata,
                      input logic slverr, input bit expect_resp);
    req_t  r;
    resp_t e;
    slv_cfg_t c;
    r.write = wr; r.addr = addr; r.wdata = wdata; r.strb = strb;
    fifo_q.push_back(r);
    if (!wr) begin r.wdata = '0; r.strb = '0; end
    exp_apb_q.push_back(r);
    c.waits = waits; c.rdata = rdata; c.slverr = slverr;
    slv_q.push_back(c);
    if (expect_resp) begin
      e.is_write = wr; e.slverr = slverr; e.rdata = wr ? 32'h0 : rdata;
      exp_resp_q.push_back(e);
    end
    refresh_fifo();
  endtask

  task automatic wait_drain(input int max_cycles, input string tag);
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk); #1;
      if (exp_resp_q.size() == 0 && fifo_q.size() == 0 && !busy) return;
    end
    check_eq({tag, "_drain_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic wait_cond(input int max_cycles, input bit want_access, input string tag);
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk); #1;
      if (want_access && psel && penable) return;
      if (!want_access && busy && !psel) return;
    end
    check_eq({tag, "_wait_timeout"}, 1'b0, 1'b1);
  endtask

  // Request FIFO model: a pop seen in one cycle removes the head after that edge.
  initial forever begin
    @(posedge clk); #1;
    if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
    pop_pending = 1'b0;
    refresh_fifo();
  end

  // APB slave: answers after cfg.waits wait states; negative waits never answers.
  initial begin
    int acc_cnt;
    slv_cfg_t cfg;
    acc_cnt = 0;
    cfg.waits = 0; cfg.rdata = '0; cfg.slverr = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (psel && penable) begin
        if (acc_cnt == 0 && slv_q.size() > 0) cfg = slv_q.pop_front();
        pready  = (cfg.waits >= 0) && (acc_cnt >= cfg.waits);
        prdata  = pready ? cfg.rdata : $urandom;
        pslverr = pready ? cfg.slverr : 1'b1;
        acc_cnt++;
      end else begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'b0;
        acc_cnt = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (req_pop) begin
        pop_cnt++;
        t_pop = cyc;
        pop_pending = 1'b1;
        if (req_empty || busy) bad_pop++;
      end
      if (psel && !penable) begin
        t_setup = cyc;
        acc_len = 0;
        if (exp_apb_q.size() == 0) check_eq("setup_unexpected", 1'b1, 1'b0);
        else begin
          cur_req = exp_apb_q.pop_front();
          check_eq("setup_bus", {pwrite, paddr, pwdata, pstrb}, cur_req);
        end
      end
      if (psel && penable) begin
        if (acc_len == 0) t_acc = cyc;
        acc_len++;
        check_eq("access_hold", {pwrite, paddr, pwdata, pstrb}, cur_req);
      end
      if (resp_push) begin
        push_cnt++;
        t_push = cyc;
        if (resp_full) bad_push++;
        if (exp_resp_q.size() == 0) check_eq("push_unexpected", 1'b1, 1'b0);
        else check_eq("resp_data", resp_data, exp_resp_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, q0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs",
             {req_pop, resp_push, resp_data, paddr, psel, penable, pwrite, pwdata, pstrb, busy}, '0);
    rst_n = 1'b1;

    // Write with immediate pready: pop, SETUP, ACCESS, push on consecutive cycles.
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 1'b1);
    wait_drain(50, "t1");
    check_eq("t1_setup_lat", t_setup - t_pop, 1);
    check_eq("t1_access_lat", t_acc - t_pop, 2);
    check_eq("t1_push_lat", t_push - t_pop, 3);
    check_eq("t1_access_len", acc_len, 1);

    // Read with three wait states.
    send(1'b0, 32'h20, 32'hCAFEF00D, 4'hA, 3, 32'h12345678, 1'b0, 1'b1);
    wait_drain(50, "t2");
    check_eq("t2_access_len", acc_len, 4);
    check_eq("t2_push_lat", t_push - t_pop, 6);

    // Response FIFO full for five cycles in RESP with another request waiting.
    resp_full = 1'b1;
    send(1'b0, 32'h30, 32'h0, 4'h0, 1, 32'hA5A5_0001, 1'b0, 1'b1);
    send(1'b1, 32'h34, 32'h0BAD_F00D, 4'h3, 0, 32'h0, 1'b0, 1'b1);
    wait_cond(50, 1'b0, "t3");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t3_push_held", resp_push, 1'b0);
      check_eq("t3_pop_held", req_pop, 1'b0);
    end
    @(posedge clk); #1;
    resp_full = 1'b0;
    @(negedge clk);
    check_eq("t3_push_release", resp_push, 1'b1);
    wait_drain(50, "t3");

    // Slave error plus three queued requests.
    p0 = pop_cnt; q0 = push_cnt;
    send(1'b0, 32'h40, 32'h0, 4'h0, 0, 32'h0000FFFF, 1'b1, 1'b1);
    send(1'b1, 32'h44, 32'h1111_2222, 4'h5, 2, 32'h0, 1'b1, 1'b1);
    send(1'b0, 32'h48, 32'h0, 4'h0, 1, 32'h8765_4321, 1'b0, 1'b1);
    wait_drain(80, "t4");
    check_eq("t4_pops", pop_cnt - p0, 3);
    check_eq("t4_pushes", push_cnt - q0, 3);

    // Reset in the middle of ACCESS.
    q0 = push_cnt;
    send(1'b0, 32'h50, 32'h0, 4'h0, 30, 32'h5555_AAAA, 1'b0, 1'b0);
    wait_cond(50, 1'b1, "t5");
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_drop", {psel, penable, busy}, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    p0 = pop_cnt;
    send(1'b1, 32'h54, 32'h7777_8888, 4'hC, 0, 32'h0, 1'b0, 1'b1);
    wait_drain(50, "t5");
    check_eq("t5_no_push", push_cnt - q0, 1);
    check_eq("t5_pop_after", pop_cnt - p0, 1);

    // Slave that never answers.
    q0 = push_cnt;
`ifdef APB_TIMEOUT_EN
    send(1'b1, 32'h60, 32'h1234_5678, 4'hF, -1, 32'h0, 1'b1, 1'b1);
    wait_drain(100, "t6");
    check_eq("t6_access_len", acc_len, 16);
    check_eq("t6_push", push_cnt - q0, 1);
`else
    send(1'b1, 32'h60, 32'h1234_5678, 4'hF, -1, 32'h0, 1'b1, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    check_eq("t6_still_access", {psel, penable}, 2'b11);
    check_eq("t6_no_push", push_cnt - q0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
`endif

    repeat (2) @(posedge clk);
    check_eq("bad_pops", bad_pop, 0);
    check_eq("bad_pushes", bad_push, 0);
    check_eq("resp_left", exp_resp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
